rm_wbeat_gen: RTL and testbench
===============================

RM_WBEAT_GEN -- requirements
Module: rm_wbeat_gen

Interface
REQ-001 SHALL have parameter EW, default 8, element width in bits.
REQ-002 SHALL have parameter OBEC, default 16, elements per W beat; power of two, >=2.
REQ-003 SHALL have parameter AW, default 32, command address width.
REQ-004 SHALL have parameter LENW, default 16, command length width in elements.
REQ-005 SHALL derive OBECW = clog2(OBEC+1) and OOFSW = clog2(OBEC).
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- cmd_val  in  1  command valid
- cmd_rdy  out  1  command ready
- cmd_addr  in  AW  start element address
- cmd_len  in  LENW  element count
- a_val  in  1  aligner output valid
- a_rdy  out  1  aligner output ready
- a_ob  in  OBEC*EW  aligner output elements
- a_oofs  out  OOFSW  requested element offset in beat
- a_oec  out  OBECW  requested element count for beat
- w_valid  out  1  W beat valid
- w_ready  in  1  W beat ready
- w_data  out  OBEC*EW  W data
- w_strb  out  OBEC  one bit per element
- w_last  out  1  final beat of command
- cmd_done  out  1  one-cycle pulse on command completion
- busy  out  1  command active or W beat pending

Function
REQ-007 SHALL implement states IDLE and ACTIVE; cmd_rdy = (state==IDLE).
REQ-008 On cmd_val&cmd_rdy with cmd_len!=0: latch ofs = cmd_addr mod OBEC and rem = cmd_len, then go to ACTIVE next cycle.
REQ-009 On cmd_val&cmd_rdy with cmd_len==0: stay IDLE, emit no beat, pulse cmd_done the next cycle.
REQ-010 In ACTIVE: a_oofs = ofs; a_oec = min(OBEC-ofs, rem), computed at LENW+1 bits without truncation; both driven from registers only and stable until the beat is taken.
REQ-011 SHALL hold one output beat register; a_rdy = ACTIVE & (!w_valid | w_ready).
REQ-012 On a_val&a_rdy: load w_data=a_ob, w_strb bits [ofs, ofs+a_oec) set and all others clear, w_last=(rem==a_oec), set w_valid; then rem -= a_oec and ofs = 0.
REQ-013 If rem reaches 0, return to IDLE next cycle; a new command SHALL be accepted while the last W beat is still pending.
REQ-014 w_valid SHALL clear on w_valid&w_ready unless reloaded in the same cycle.
REQ-015 While w_valid&!w_ready, w_data, w_strb and w_last SHALL hold stable.
REQ-016 cmd_done SHALL pulse one cycle after the handshake of a beat with w_last=1.
REQ-017 busy = (state==ACTIVE) | w_valid.
REQ-018 cmd_len = 2^LENW-1 SHALL complete correctly with no counter overflow.
REQ-019 a_val while IDLE SHALL be ignored; a_rdy=0 in IDLE.

Reset
REQ-020 On rstn=0 at a clk edge, including mid-command: state=IDLE, rem=0, ofs=0, w_valid=0, w_last=0, w_strb=0, w_data=0, cmd_done=0, busy=0; the command in progress SHALL be discarded.
REQ-021 During and after reset: cmd_rdy=1, a_rdy=0, a_oofs=0, a_oec=0.

Verification (OBEC=16, EW=8)
REQ-022 addr=0x0, len=32, w_ready=1 -> 2 beats, oofs=0/oec=16 each, strb FFFF,FFFF, last on beat 2, cmd_done 1 cycle later.
REQ-023 addr=0x5, len=8 -> 1 beat, oofs=5, oec=8, strb 0x1FE0, w_last=1.
REQ-024 addr=0xC, len=40 -> 4 beats (oofs,oec) = (12,4),(0,16),(0,16),(0,4); strb F000,FFFF,FFFF,000F; last on beat 4.
REQ-025 w_ready=0 for 5 cycles with a beat pending -> W outputs stable, a_rdy=0, no aligner pop; beat completes after w_ready rises.
REQ-026 len=0 -> cmd accepted, no W beat, cmd_done pulses next cycle; busy stays 0.
REQ-027 rstn=0 after beat 2 of the REQ-024 command -> all outputs at reset values; a following command addr=0, len=16 produces exactly 1 beat, strb FFFF, last=1.

Source files
------------

// File: rtl/rm_wbeat_gen.sv
// rtl/rm_wbeat_gen.sv - W beat generator: slices a command into aligned beats
// with per-element strobes, pulling element data from an upstream aligner.
module rm_wbeat_gen #(
  parameter int EW   = 8,
  parameter int OBEC = 16,
  parameter int AW   = 32,
  parameter int LENW = 16,
  localparam int OBECW = $clog2(OBEC + 1),
  localparam int OOFSW = $clog2(OBEC)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_val,
  output logic                 cmd_rdy,
  input  logic [AW-1:0]        cmd_addr,
  input  logic [LENW-1:0]      cmd_len,
  input  logic                 a_val,
  output logic                 a_rdy,
  input  logic [OBEC*EW-1:0]   a_ob,
  output logic [OOFSW-1:0]     a_oofs,
  output logic [OBECW-1:0]     a_oec,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [OBEC*EW-1:0]   w_data,
  output logic [OBEC-1:0]      w_strb,
  output logic                 w_last,
  output logic                 cmd_done,
  output logic                 busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [OOFSW-1:0] ofs;
  logic [LENW-1:0]  rem;
  logic [LENW:0]    room;
  logic [LENW:0]    rem_x;
  logic [LENW:0]    oec_full;
  logic [OBECW:0]   ofs_x;
  logic [OBECW:0]   end_x;
  logic [OBEC-1:0]  nxt_strb;
  logic             active;
  logic             take_a;
  logic             last_beat;
  logic             unused_addr;

  // Only the in-beat offset of the start address matters here.
  assign unused_addr = ^cmd_addr[AW-1:OOFSW];

  assign active    = (state == ACTIVE);
  assign cmd_rdy   = ~active;
  assign a_rdy     = active & (~w_valid | w_ready);
  assign take_a    = a_val & a_rdy;
  assign busy      = active | w_valid;
  assign last_beat = (oec_full == rem_x);

  // Extra bit keeps min(OBEC-ofs, rem) exact for rem up to 2^LENW-1.
  always_comb begin
    room     = (LENW+1)'(OBEC) - (LENW+1)'(ofs);
    rem_x    = (LENW+1)'(rem);
    oec_full = (room < rem_x) ? room : rem_x;
  end

  assign a_oofs = active ? ofs : '0;
  assign a_oec  = active ? OBECW'(oec_full) : '0;

  always_comb begin
    ofs_x    = (OBECW+1)'(ofs);
    end_x    = ofs_x + (OBECW+1)'(oec_full);
    nxt_strb = '0;
    for (int i = 0; i < OBEC; i++) begin
      nxt_strb[i] = ((OBECW+1)'(i) >= ofs_x) && ((OBECW+1)'(i) < end_x);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      ofs      <= '0;
      rem      <= '0;
      w_valid  <= 1'b0;
      w_last   <= 1'b0;
      w_strb   <= '0;
      w_data   <= '0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= w_valid & w_ready & w_last;
      if (w_valid && w_ready) begin
        w_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_val) begin
            if (cmd_len != '0) begin
              ofs   <= cmd_addr[OOFSW-1:0];
              rem   <= cmd_len;
              state <= ACTIVE;
            end else begin
              cmd_done <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // Loading here overrides the clear above when the beat is reloaded.
          if (take_a) begin
            w_data  <= a_ob;
            w_strb  <= nxt_strb;
            w_last  <= last_beat;
            w_valid <= 1'b1;
            rem     <= rem - oec_full[LENW-1:0];
            ofs     <= '0;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rm_wbeat_gen.sv
// tb/tb_rm_wbeat_gen.sv - self-checking bench for rm_wbeat_gen.
module tb_rm_wbeat_gen;
  localparam int EW = 8, OBEC = 16, AW = 32, LENW = 16;
  localparam int OBECW = 5, OOFSW = 4, DW = OBEC * EW;

  logic clk = 1'b0;
  logic rstn, cmd_val, cmd_rdy, a_val, a_rdy, w_valid, w_ready, w_last, cmd_done, busy;
  logic [AW-1:0] cmd_addr;
  logic [LENW-1:0] cmd_len;
  logic [DW-1:0] a_ob, w_data;
  logic [OOFSW-1:0] a_oofs;
  logic [OBECW-1:0] a_oec;
  logic [OBEC-1:0] w_strb;

  rm_wbeat_gen #(.EW(EW), .OBEC(OBEC), .AW(AW), .LENW(LENW)) dut (
    .clk(clk), .rstn(rstn), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .a_val(a_val), .a_rdy(a_rdy),
    .a_ob(a_ob), .a_oofs(a_oofs), .a_oec(a_oec), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .cmd_done(cmd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [LENW-1:0] len;
    int              nb;
    logic [3:0][15:0] strb;
    int              mode;
  } vec_t;

  vec_t tbl[7];
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [DW-1:0] data_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [OBECW-1:0] popc(input logic [15:0] s);
    logic [OBECW-1:0] n = '0;
    for (int i = 0; i < 16; i++) n += OBECW'(s[i]);
    return n;
  endfunction

  function automatic logic [OOFSW-1:0] lowbit(input logic [15:0] s);
    for (int i = 15; i >= 0; i--) if (s[i]) lowbit = OOFSW'(i);
  endfunction

  // Each element k lands at address addr+k; beat and strobe bit follow from that.
  task automatic model(input logic [AW-1:0] addr, input int len);
    int g, b;
    logic [15:0] t;
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      g = int'(addr[3:0]) + k;
      b = g / 16;
      if (b == exp_q.size()) exp_q.push_back(16'h0);
      t = exp_q[b];
      t[g % 16] = 1'b1;
      exp_q[b] = t;
    end
  endtask

  task automatic chk_reset();
    check("rst_w_valid", w_valid, 0);
    check("rst_w_last", w_last, 0);
    check("rst_w_strb", w_strb, 0);
    check("rst_w_data", w_data, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_rdy", cmd_rdy, 1);
    check("rst_a_rdy", a_rdy, 0);
    check("rst_a_oofs", a_oofs, 0);
    check("rst_a_oec", a_oec, 0);
  endtask

  // mode 0: always ready; 1: random handshakes; 2: w_ready held low 5 cycles.
  task automatic run_cmd(input logic [AW-1:0] addr, input logic [LENW-1:0] len, input int mode);
    int nb, pops, taken, cyc, stall;
    bit done_exp, hold, fin;
    logic [DW-1:0] hd;
    logic [15:0] hs;
    logic hl;
    nb = exp_q.size(); pops = 0; taken = 0; cyc = 0; stall = 0;
    done_exp = 0; hold = 0; fin = 0;
    data_q.delete();
    @(negedge clk);
    a_val = 0; w_ready = 0; cmd_val = 1; cmd_addr = addr; cmd_len = len;
    #1 check("cmd_rdy_idle", cmd_rdy, 1);
    @(negedge clk);
    cmd_val = 0;
    while (!fin && cyc < 20 * nb + 50) begin
      case (mode)
        0: begin a_val = 1; w_ready = 1; end
        1: begin a_val = 1'($urandom_range(0, 1)); w_ready = 1'($urandom_range(0, 1)); end
        default: begin a_val = 1; w_ready = (stall >= 5); end
      endcase
      a_ob = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("cmd_done", cmd_done, done_exp);
      done_exp = 0;
      if (taken == nb) begin
        check("busy_end", busy, 0);
        fin = 1;
      end else begin
        check("a_rdy", a_rdy, (pops < nb) && (!(pops > taken) || w_ready));
        check("w_valid", w_valid, pops > taken);
        check("busy", busy, (pops < nb) || (pops > taken));
        check("cmd_rdy", cmd_rdy, pops == nb);
        if (hold) begin
          check("hold_data", w_data, hd);
          check("hold_strb", w_strb, hs);
          check("hold_last", w_last, hl);
          hold = 0;
        end
        if (w_valid && w_ready) begin
          check("w_data", w_data, data_q.pop_front());
          check("w_strb", w_strb, exp_q[taken]);
          check("w_last", w_last, taken == nb - 1);
          if (taken == nb - 1) done_exp = 1;
          taken++;
        end else if (w_valid) begin
          hold = 1; hd = w_data; hs = w_strb; hl = w_last;
          stall++;
        end
        if (a_val && a_rdy) begin
          check("a_oofs", a_oofs, lowbit(exp_q[pops]));
          check("a_oec", a_oec, popc(exp_q[pops]));
          data_q.push_back(a_ob);
          pops++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("beat_count", taken, nb);
    check("finished", fin, 1);
    a_val = 0; w_ready = 0;
  endtask

  initial begin
    int wt, cyc;
    rstn = 0; cmd_val = 0; cmd_addr = '0; cmd_len = '0; a_val = 0; a_ob = '0; w_ready = 0;
    tbl[0] = '{32'h0,  16'd32, 2, {16'h0, 16'h0, 16'hFFFF, 16'hFFFF}, 0};
    tbl[1] = '{32'h5,  16'd8,  1, {16'h0, 16'h0, 16'h0, 16'h1FE0}, 0};
    tbl[2] = '{32'hC,  16'd40, 4, {16'h000F, 16'hFFFF, 16'hFFFF, 16'hF000}, 0};
    tbl[3] = '{32'h0,  16'd32, 2, {16'h0, 16'h0, 16'hFFFF, 16'hFFFF}, 2};
    tbl[4] = '{32'h1F, 16'd1,  1, {16'h0, 16'h0, 16'h0, 16'h8000}, 1};
    tbl[5] = '{32'hF,  16'd2,  2, {16'h0, 16'h0, 16'h0001, 16'h8000}, 1};
    tbl[6] = '{32'h3,  16'd16, 2, {16'h0, 16'h0, 16'h0007, 16'hFFF8}, 2};
    repeat (2) @(negedge clk);
    #1 chk_reset();
    @(negedge clk);
    rstn = 1;

    for (int v = 0; v < 7; v++) begin
      exp_q.delete();
      for (int b = 0; b < tbl[v].nb; b++) exp_q.push_back(tbl[v].strb[b]);
      run_cmd(tbl[v].addr, tbl[v].len, tbl[v].mode);
    end

    // Zero-length command: accepted, no beat, done pulse next cycle.
    @(negedge clk);
    cmd_val = 1; cmd_len = 0; cmd_addr = 32'h7;
    #1 check("len0_cmd_rdy", cmd_rdy, 1);
    @(negedge clk);
    cmd_val = 0;
    #1 check("len0_done", cmd_done, 1);
    check("len0_busy", busy, 0);
    check("len0_w_valid", w_valid, 0);
    @(negedge clk);
    #1 check("len0_done_clr", cmd_done, 0);
    check("len0_w_valid2", w_valid, 0);

    // Reset in the middle of a 4-beat command, then a fresh command.
    @(negedge clk);
    cmd_val = 1; cmd_addr = 32'hC; cmd_len = 16'd40;
    @(negedge clk);
    cmd_val = 0; a_val = 1; w_ready = 1;
    wt = 0; cyc = 0;
    while (wt < 2 && cyc < 20) begin
      #1 if (w_valid && w_ready) wt++;
      @(negedge clk);
      cyc++;
    end
    check("mid_beats", wt, 2);
    rstn = 0;
    @(negedge clk);
    #1 chk_reset();
    rstn = 1; a_val = 0; w_ready = 0;
    exp_q.delete();
    exp_q.push_back(16'hFFFF);
    run_cmd(32'h0, 16'd16, 0);

    // Maximum length.
    model(32'h0, 65535);
    run_cmd(32'h0, 16'hFFFF, 0);

    for (int r = 0; r < 40; r++) begin
      logic [AW-1:0] ad;
      logic [LENW-1:0] ln;
      ad = $urandom;
      ln = LENW'($urandom_range(1, 70));
      model(ad, int'(ln));
      run_cmd(ad, ln, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
